uart_line_buffer: RTL and testbench

- Sits directly downstream of the uart receive interface: consumes the uart_rd_data/valid/ready byte stream and assembles characters into a line buffer.
- Applies backspace editing, drops LF and empty lines, and truncates lines that are too long.
- On CR, replays the complete edited line as a valid/ready byte stream with a last marker, line length and truncation flag, for a downstream command parser.

---
 rtl/uart_line_buffer.sv | 122 ++++++++++++
 tb/tb_uart_line_buffer.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_line_buffer.sv
// Line assembler behind the uart receiver: applies backspace edits, drops LF and
// empty lines, truncates at DEPTH chars, and on CR replays the line as a byte stream.
module uart_line_buffer #(
  parameter int DEPTH = 64,
  parameter int CNT_W = 7
) (
  input  logic             uart_clk,
  input  logic             uart_rst,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [CNT_W-1:0] line_len,
  output logic             line_ovf
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] DRAIN   = 1'b1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  // Reset asserts immediately, releases two edges later in this clock domain.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge uart_clk or negedge uart_rst) begin
    if (!uart_rst) rst_sync_q <= 2'b00;
    else           rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             ovf_q, ovf_d;
  logic             lovf_q, lovf_d;
  logic             mem_we;
  logic [7:0]       mem_q [DEPTH];

  assign in_ready  = rst_n && (state_q == COLLECT);
  assign out_valid = (state_q == DRAIN);
  assign out_data  = out_valid ? mem_q[rd_ptr_q[AW-1:0]] : 8'h00;
  assign out_last  = out_valid && (rd_ptr_q == len_q - ONE_C);
  assign line_len  = out_valid ? len_q : '0;
  assign line_ovf  = out_valid && lovf_q;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    len_d    = len_q;
    ovf_d    = ovf_q;
    lovf_d   = lovf_q;
    mem_we   = 1'b0;
    if (state_q == COLLECT) begin
      if (in_valid && in_ready) begin
        case (in_data)
          8'h0D: begin
            if (count_q != '0) begin
              len_d    = count_q;
              lovf_d   = ovf_q;
              rd_ptr_d = '0;
              state_d  = DRAIN;
            end
          end
          8'h0A: begin
          end
          8'h08, 8'h7F: begin
            if (count_q != '0) count_d = count_q - ONE_C;
          end
          default: begin
            // Overflow sticks until the line is drained; backspace does not clear it.
            if (count_q < DEPTH_C) begin
              mem_we  = 1'b1;
              count_d = count_q + ONE_C;
            end else begin
              ovf_d = 1'b1;
            end
          end
        endcase
      end
    end else if (out_ready) begin
      if (out_last) begin
        state_d  = COLLECT;
        count_d  = '0;
        rd_ptr_d = '0;
        ovf_d    = 1'b0;
      end else begin
        rd_ptr_d = rd_ptr_q + ONE_C;
      end
    end
  end

  always_ff @(posedge uart_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= COLLECT;
      count_q  <= '0;
      rd_ptr_q <= '0;
      len_q    <= '0;
      ovf_q    <= 1'b0;
      lovf_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      len_q    <= len_d;
      ovf_q    <= ovf_d;
      lovf_q   <= lovf_d;
    end
  end

  // Storage needs no reset; only entries below count are ever read.
  always_ff @(posedge uart_clk) begin
    if (mem_we) mem_q[count_q[AW-1:0]] <= in_data;
  end

endmodule

// File: tb/tb_uart_line_buffer.sv
// Bench for uart_line_buffer: cycle vector table, directed corner sequences and
// random traffic checked against a queue-based line model.
module tb_uart_line_buffer;

  logic       uart_clk = 1'b0;
  logic       uart_rst = 1'b0;
  logic [7:0] in_data  = 8'h00;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       sel = 1'b0;

  logic       a_in_ready, a_out_valid, a_out_last, a_line_ovf;
  logic [7:0] a_out_data;
  logic [6:0] a_line_len;
  logic       b_in_ready, b_out_valid, b_out_last, b_line_ovf;
  logic [7:0] b_out_data;
  logic [6:0] b_line_len;

  uart_line_buffer #(.DEPTH(64), .CNT_W(7)) u_dut_a (
    .uart_clk(uart_clk), .uart_rst(uart_rst),
    .in_data(in_data), .in_valid(in_valid & ~sel), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(out_ready & ~sel),
    .out_last(a_out_last), .line_len(a_line_len), .line_ovf(a_line_ovf)
  );

  uart_line_buffer #(.DEPTH(4), .CNT_W(7)) u_dut_b (
    .uart_clk(uart_clk), .uart_rst(uart_rst),
    .in_data(in_data), .in_valid(in_valid & sel), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(out_ready & sel),
    .out_last(b_out_last), .line_len(b_line_len), .line_ovf(b_line_ovf)
  );

  logic       o_in_ready, o_out_valid, o_out_last, o_line_ovf;
  logic [7:0] o_out_data;
  logic [6:0] o_line_len;
  assign o_in_ready  = sel ? b_in_ready  : a_in_ready;
  assign o_out_valid = sel ? b_out_valid : a_out_valid;
  assign o_out_last  = sel ? b_out_last  : a_out_last;
  assign o_line_ovf  = sel ? b_line_ovf  : a_line_ovf;
  assign o_out_data  = sel ? b_out_data  : a_out_data;
  assign o_line_len  = sel ? b_line_len  : a_line_len;

  always #5 uart_clk = ~uart_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the edited line as a queue, and the expected output stream.
  typedef struct {
    logic [7:0] d;
    logic       last;
    logic [6:0] len;
    logic       ovf;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] line_q[$];
  logic       m_ovf = 1'b0;
  int         lines_done = 0;
  int         ov_cycles = 0;
  int         nrdy_cycles = 0;
  logic       mon_en = 1'b0;
  logic       prev_stall = 1'b0;
  logic [7:0] p_d;
  logic       p_last, p_ovf;
  logic [6:0] p_len;

  function automatic void model_in(input logic [7:0] b);
    int depth = sel ? 4 : 64;
    int n = line_q.size();
    if (b == 8'h0D) begin
      if (n > 0) begin
        for (int i = 0; i < n; i++)
          exp_q.push_back('{line_q[i], (i == n - 1), 7'(n), m_ovf});
        line_q.delete();
        m_ovf = 1'b0;
      end
    end else if (b == 8'h0A) begin
    end else if (b == 8'h08 || b == 8'h7F) begin
      if (n > 0) void'(line_q.pop_back());
    end else if (n < depth) begin
      line_q.push_back(b);
    end else begin
      m_ovf = 1'b1;
    end
  endfunction

  function automatic void model_clear();
    exp_q.delete();
    line_q.delete();
    m_ovf = 1'b0;
    prev_stall = 1'b0;
  endfunction

  // Inputs change just after posedge, so values at negedge decide the next transfer.
  always @(negedge uart_clk) begin
    if (mon_en && uart_rst) begin
      exp_t e;
      check("ready_valid_exclusive", {31'd0, o_in_ready & o_out_valid}, 32'd0);
      if (o_out_valid) ov_cycles++;
      if (!o_in_ready) nrdy_cycles++;
      if (prev_stall) begin
        check("hold_valid", {31'd0, o_out_valid}, 32'd1);
        check("hold_data", {24'd0, o_out_data}, {24'd0, p_d});
        check("hold_last", {31'd0, o_out_last}, {31'd0, p_last});
        check("hold_len", {25'd0, o_line_len}, {25'd0, p_len});
        check("hold_ovf", {31'd0, o_line_ovf}, {31'd0, p_ovf});
      end
      prev_stall = o_out_valid && !out_ready;
      p_d = o_out_data; p_last = o_out_last; p_len = o_line_len; p_ovf = o_line_ovf;
      if (in_valid && o_in_ready) model_in(in_data);
      if (o_out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", {24'd0, o_out_data}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("out_data", {24'd0, o_out_data}, {24'd0, e.d});
          check("out_last", {31'd0, o_out_last}, {31'd0, e.last});
          check("line_len", {25'd0, o_line_len}, {25'd0, e.len});
          check("line_ovf", {31'd0, o_line_ovf}, {31'd0, e.ovf});
          if (e.last) lines_done++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge uart_clk); #1;
  endtask

  task automatic send(input logic [7:0] b);
    int t = 0;
    in_data = b; in_valid = 1'b1;
    @(negedge uart_clk);
    while (!o_in_ready && t < 300) begin
      t++;
      @(negedge uart_clk);
    end
    if (!o_in_ready) check("send_timeout", 32'd0, 32'd1);
    @(posedge uart_clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((o_out_valid || exp_q.size() != 0) && t < 3000) begin
      tick();
      t++;
    end
    check("idle_timeout", {31'd0, (t < 3000)}, 32'd1);
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!o_in_ready && t < 20) begin
      tick();
      t++;
    end
    check("ready_after_reset", {31'd0, o_in_ready}, 32'd1);
  endtask

  task automatic rand_traffic(input int n);
    logic done = 1'b0;
    fork
      begin
        for (int i = 0; i < n; i++) begin
          int r = $urandom_range(0, 99);
          logic [7:0] b;
          if (r < 8)       b = 8'h0D;
          else if (r < 11) b = 8'h0A;
          else if (r < 16) b = 8'h08;
          else if (r < 19) b = 8'h7F;
          else             b = 8'($urandom_range(0, 255));
          send(b);
        end
        send(8'h0D);
        done = 1'b1;
      end
      begin
        while (!done) begin
          tick();
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    wait_idle();
  endtask

  typedef struct {
    logic       iv;
    logic [7:0] id;
    logic       ordy;
    logic       e_ir;
    logic       e_ov;
    logic [7:0] e_od;
    logic       e_last;
    logic [6:0] e_len;
    logic       e_ovf;
  } vec_t;

  vec_t tbl[12];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    string hs;
    int base, base_ov, base_nr;
    hs = "Hello";
    for (int i = 0; i < 5; i++) begin
      tbl[i]     = '{1'b1, hs[i], 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 7'd0, 1'b0};
      tbl[6 + i] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, hs[i], (i == 4), 7'd5, 1'b0};
    end
    tbl[5]  = '{1'b1, 8'h0D, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 7'd0, 1'b0};
    tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 7'd0, 1'b0};

    // Reset state
    #12;
    check("rst_in_ready", {31'd0, o_in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, o_out_valid}, 32'd0);
    check("rst_out_last", {31'd0, o_out_last}, 32'd0);
    check("rst_line_len", {25'd0, o_line_len}, 32'd0);
    check("rst_line_ovf", {31'd0, o_line_ovf}, 32'd0);
    check("rst_out_data", {24'd0, o_out_data}, 32'd0);
    tick();
    uart_rst = 1'b1;
    wait_ready();
    mon_en = 1'b1;

    // Cycle-exact "Hello"+CR
    for (int i = 0; i < 12; i++) begin
      in_valid = tbl[i].iv; in_data = tbl[i].id; out_ready = tbl[i].ordy;
      @(negedge uart_clk);
      check($sformatf("tbl%0d_in_ready", i), {31'd0, o_in_ready}, {31'd0, tbl[i].e_ir});
      check($sformatf("tbl%0d_out_valid", i), {31'd0, o_out_valid}, {31'd0, tbl[i].e_ov});
      if (tbl[i].e_ov) begin
        check($sformatf("tbl%0d_data", i), {24'd0, o_out_data}, {24'd0, tbl[i].e_od});
        check($sformatf("tbl%0d_last", i), {31'd0, o_out_last}, {31'd0, tbl[i].e_last});
        check($sformatf("tbl%0d_len", i), {25'd0, o_line_len}, {25'd0, tbl[i].e_len});
        check($sformatf("tbl%0d_ovf", i), {31'd0, o_line_ovf}, {31'd0, tbl[i].e_ovf});
      end
      tick();
    end
    in_valid = 1'b0;

    // Backspace editing, trailing LF
    base = lines_done;
    send_str("Helxx"); send(8'h08); send(8'h7F); send_str("lo"); send(8'h0D); send(8'h0A);
    wait_idle();
    repeat (2) tick();
    check("bs_lines", lines_done - base, 32'd1);
    check("bs_lf_no_out", {31'd0, o_out_valid}, 32'd0);

    // Empty lines produce nothing
    base = lines_done; base_ov = ov_cycles; base_nr = nrdy_cycles;
    send(8'h0D); send(8'h0A); send(8'h08); send(8'h0D);
    repeat (3) tick();
    check("empty_no_valid", ov_cycles - base_ov, 32'd0);
    check("empty_ready_high", nrdy_cycles - base_nr, 32'd0);
    check("empty_lines", lines_done - base, 32'd0);
    base = lines_done;
    send_str("Z"); send(8'h0D);
    wait_idle();
    check("empty_count_zero", lines_done - base, 32'd1);

    // Truncation on the DEPTH=4 instance
    sel = 1'b1;
    tick();
    base = lines_done;
    send_str("ABCDEF"); send(8'h0D);
    wait_idle();
    check("trunc_lines", lines_done - base, 32'd1);
    sel = 1'b0;
    tick();

    // Truncation at DEPTH=64
    base = lines_done;
    for (int i = 0; i < 70; i++) send(8'h61 + 8'(i % 26));
    send(8'h0D);
    wait_idle();
    check("trunc64_lines", lines_done - base, 32'd1);

    // Stalled drain with a second line queued upstream
    out_ready = 1'b0;
    base = lines_done;
    send_str("Hi"); send(8'h0D);
    @(negedge uart_clk);
    check("stall_first_valid", {31'd0, o_out_valid}, 32'd1);
    check("stall_first_data", {24'd0, o_out_data}, 32'h48);
    tick();
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          out_ready = i[0];
          tick();
        end
      end
      begin
        send_str("Yo"); send(8'h0D);
      end
    join
    out_ready = 1'b1;
    wait_idle();
    check("stall_lines", lines_done - base, 32'd2);

    // Reset in the middle of a drain
    out_ready = 1'b1;
    send_str("Hello"); send(8'h0D);
    tick();
    mon_en = 1'b0;
    uart_rst = 1'b0;
    #1;
    check("midrst_out_valid", {31'd0, o_out_valid}, 32'd0);
    check("midrst_in_ready", {31'd0, o_in_ready}, 32'd0);
    check("midrst_line_len", {25'd0, o_line_len}, 32'd0);
    model_clear();
    repeat (2) tick();
    uart_rst = 1'b1;
    wait_ready();
    mon_en = 1'b1;
    base = lines_done;
    send_str("OK"); send(8'h0D);
    wait_idle();
    check("midrst_lines", lines_done - base, 32'd1);

    // Random traffic on both depths
    base = lines_done;
    rand_traffic(300);
    sel = 1'b1;
    tick();
    rand_traffic(150);
    sel = 1'b0;
    tick();
    check("rand_some_lines", {31'd0, (lines_done > base)}, 32'd1);
    check("rand_model_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
